stat_update_ctrl: RTL and testbench
===================================

Name: stat_update_ctrl

Overview:
- Read-modify-write sequencer sitting directly upstream of the status register file wrapper.
- Accepts per-line status operations (lookup, touch, fill, invalidate) from the cache controller.
- For each one it issues a read, waits for the read data, computes the new {use, block_valid, spare} word, issues the write, and returns the prior status to the requester.
- Serialises all status traffic, so the status register file never sees a read and a write to the same line interleaved.

Parameters:
- ADDR_WIDTH, 3, width of the line address, which is the status register file depth as log2.

Ports:
- clk  in  1  clock; everything is rising-edge.
- arst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  operation request.
- o_req_ready  out  1  high only in IDLE.
- i_req_op  in  2  operation: 0 LOOKUP, 1 TOUCH, 2 FILL, 3 INVAL.
- i_req_addr  in  ADDR_WIDTH  line address.
- o_rsp_valid  out  1  response available; held until accepted.
- i_rsp_ready  in  1  response accept.
- o_rsp_was_valid  out  1  block_valid before the op.
- o_rsp_was_used  out  1  use bit before the op.
- o_rsp_spare  out  1  spare bit before the op.
- o_srf_addr  out  ADDR_WIDTH  to the status register file i_addr.
- o_srf_use  out  1  write data, use bit.
- o_srf_block_valid  out  1  write data, valid bit.
- o_srf_spare_bit  out  1  write data, spare bit.
- o_srf_wen  out  1  1 = write, 0 = read.
- o_srf_valid  out  1  command strobe.
- i_srf_use  in  1  read data, use bit.
- i_srf_block_valid  in  1  read data, valid bit (already init-qualified).
- i_srf_spare_bit  in  1  read data, spare bit.
- i_srf_valid  in  1  read data valid.
- i_srf_freeze  in  1  status register file cannot take a command this cycle.

Behaviour:
- All outputs are registered. Reset value of every output is 0, except o_req_ready, which is 1.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RSP.
- IDLE:
  - On i_req_valid & o_req_ready, latch op and addr and go to RD_ISSUE.
  - o_req_ready drops on the next cycle.
- RD_ISSUE:
  - Drive o_srf_valid=1, o_srf_wen=0, o_srf_addr=latched addr.
  - A cycle with i_srf_freeze=0 counts as the accept cycle; go to RD_WAIT.
  - If i_srf_freeze=1, hold all command outputs unchanged and retry next cycle.
  - o_srf_valid is high for exactly one un-frozen cycle per command.
- RD_WAIT:
  - o_srf_valid=0.
  - On i_srf_valid, capture {i_srf_use, i_srf_block_valid, i_srf_spare_bit} into the prior-status registers.
  - Then go to RSP if the op is LOOKUP, otherwise to WR_ISSUE.
  - i_srf_valid in any other state is ignored.
- WR_ISSUE:
  - Drive o_srf_valid=1, o_srf_wen=1, same addr, and new data derived from the captured prior status:
    - TOUCH: use=1, valid and spare unchanged.
    - FILL: use=1, valid=1, spare=0.
    - INVAL: use=0, valid=0, spare unchanged.
  - Freeze rule is the same as RD_ISSUE. On accept, go to RSP; write completion is not awaited.
- RSP:
  - o_rsp_valid=1 with the prior status.
  - Go to IDLE on i_rsp_ready.
  - o_req_ready returns to 1 on the cycle after the handshake.
- Minimum occupancy, with no freeze and read latency L cycles after the accept: LOOKUP is 2+L+1 cycles, writing ops are 3+L+1 cycles (accept to response handshake, i_rsp_ready tied high).
- Boundaries:
  - An INVAL on an already-invalid line still performs the write.
  - A FILL on a valid line still performs the write, and o_rsp_was_valid=1 flags it.
  - Addresses 0 and 2^ADDR_WIDTH-1 need no special handling.
  - arst mid-operation returns to IDLE immediately and drops o_srf_valid and o_rsp_valid. An in-flight status register file command is abandoned, and a later stray i_srf_valid is ignored.
  - Request fields are sampled only at acceptance; changes while busy have no effect.

Decomposition:
- Shared package (stat_pkg) holds:
  - op encodings OP_LOOKUP=2'd0, OP_TOUCH=2'd1, OP_FILL=2'd2, OP_INVAL=2'd3;
  - FSM state encoding;
  - status-word bit positions USE=2, VALID=1, SPARE=0.
- One natural sub-module is stat_next_word, the combinational new-word function of op and prior status. Everything else stays in the top level.

Test Plan:
- Reset, then TOUCH addr 5 with prior read {0,1,0}, L=1 → read command at addr 5 with wen=0, then write with wen=1, data {1,1,0}; response was_valid=1, was_used=0.
- FILL addr 0 with prior {1,0,1} → write data {1,1,0}; response {used=1, valid=0, spare=1}.
- LOOKUP addr 7 → exactly one read strobe, no write strobe, response returns the read data.
- i_srf_freeze high for 3 cycles during RD_ISSUE, then during WR_ISSUE → commands held stable; exactly one strobe accepted for each.
- INVAL with i_rsp_ready low for 4 cycles → o_rsp_valid and data stay stable; a new i_req_valid is not accepted until after the handshake.
- arst asserted in RD_WAIT, then i_srf_valid arrives → all outputs are at reset values, o_req_ready=1, and no response is produced.

Source files
------------

// File: rtl/stat_pkg.sv
// Shared encodings for the status read-modify-write sequencer:
// op codes, FSM states and status-word bit positions.
package stat_pkg;

    localparam logic [1:0] OP_LOOKUP = 2'd0;
    localparam logic [1:0] OP_TOUCH  = 2'd1;
    localparam logic [1:0] OP_FILL   = 2'd2;
    localparam logic [1:0] OP_INVAL  = 2'd3;

    localparam logic [2:0] ST_IDLE     = 3'd0;  // waiting for a request
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;  // read strobe up until un-frozen
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;  // waiting for read data
    localparam logic [2:0] ST_WR_ISSUE = 3'd3;  // write strobe up until un-frozen
    localparam logic [2:0] ST_RSP      = 3'd4;  // prior status held for requester

    localparam int unsigned USE   = 2;
    localparam int unsigned VALID = 1;
    localparam int unsigned SPARE = 0;

    typedef logic [2:0] stat_word_t;

    function automatic stat_word_t pack_status(input logic use_bit,
                                               input logic valid_bit,
                                               input logic spare_bit);
        stat_word_t w;
        w        = '0;
        w[USE]   = use_bit;
        w[VALID] = valid_bit;
        w[SPARE] = spare_bit;
        return w;
    endfunction

endpackage

// File: rtl/stat_next_word.sv
// New status word as a function of the operation and the prior status.
module stat_next_word
    import stat_pkg::*;
(
    input  logic [1:0] op,
    input  logic [2:0] prior,
    output logic [2:0] next_word
);

    always_comb begin
        next_word = prior;
        case (op)
            OP_TOUCH: begin
                next_word[USE] = 1'b1;
            end
            OP_FILL: begin
                next_word[USE]   = 1'b1;
                next_word[VALID] = 1'b1;
                next_word[SPARE] = 1'b0;
            end
            OP_INVAL: begin
                next_word[USE]   = 1'b0;
                next_word[VALID] = 1'b0;
            end
            default: begin
                next_word = prior;
            end
        endcase
    end

endmodule

// File: rtl/stat_update_ctrl.sv
// Serialising read-modify-write sequencer in front of the status register file.
// Every output is a flop; next values are prepared one cycle ahead from state_d.
module stat_update_ctrl
    import stat_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_op,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic                  o_rsp_was_valid,
    output logic                  o_rsp_was_used,
    output logic                  o_rsp_spare,
    output logic [ADDR_WIDTH-1:0] o_srf_addr,
    output logic                  o_srf_use,
    output logic                  o_srf_block_valid,
    output logic                  o_srf_spare_bit,
    output logic                  o_srf_wen,
    output logic                  o_srf_valid,
    input  logic                  i_srf_use,
    input  logic                  i_srf_block_valid,
    input  logic                  i_srf_spare_bit,
    input  logic                  i_srf_valid,
    input  logic                  i_srf_freeze
);

    logic [2:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            prior_q, prior_d;
    logic [2:0]            wdata_q, wdata_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  srf_valid_q, srf_valid_d;
    logic                  srf_wen_q, srf_wen_d;

    logic [2:0]            rd_word;
    logic [2:0]            new_word;

    assign rd_word = pack_status(i_srf_use, i_srf_block_valid, i_srf_spare_bit);

    // Computed from the live read data so the write word is ready on WR_ISSUE entry.
    stat_next_word u_next_word (
        .op        (op_q),
        .prior     (rd_word),
        .next_word (new_word)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        prior_d     = prior_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        srf_valid_d = srf_valid_q;
        srf_wen_d   = srf_wen_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid && req_ready_q) begin
                    state_d     = ST_RD_ISSUE;
                    op_d        = i_req_op;
                    addr_d      = i_req_addr;
                    wdata_d     = '0;
                    req_ready_d = 1'b0;
                    srf_valid_d = 1'b1;
                    srf_wen_d   = 1'b0;
                end
            end
            ST_RD_ISSUE: begin
                if (!i_srf_freeze) begin
                    state_d     = ST_RD_WAIT;
                    srf_valid_d = 1'b0;
                end
            end
            ST_RD_WAIT: begin
                if (i_srf_valid) begin
                    prior_d = rd_word;
                    if (op_q == OP_LOOKUP) begin
                        state_d     = ST_RSP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d     = ST_WR_ISSUE;
                        wdata_d     = new_word;
                        srf_valid_d = 1'b1;
                        srf_wen_d   = 1'b1;
                    end
                end
            end
            ST_WR_ISSUE: begin
                // Write completion is not awaited; accept alone retires the command.
                if (!i_srf_freeze) begin
                    state_d     = ST_RSP;
                    srf_valid_d = 1'b0;
                    srf_wen_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                srf_valid_d = 1'b0;
                srf_wen_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LOOKUP;
            addr_q      <= '0;
            prior_q     <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            srf_valid_q <= 1'b0;
            srf_wen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            prior_q     <= prior_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            srf_valid_q <= srf_valid_d;
            srf_wen_q   <= srf_wen_d;
        end
    end

    assign o_req_ready       = req_ready_q;
    assign o_rsp_valid       = rsp_valid_q;
    assign o_rsp_was_used    = prior_q[USE];
    assign o_rsp_was_valid   = prior_q[VALID];
    assign o_rsp_spare       = prior_q[SPARE];
    assign o_srf_addr        = addr_q;
    assign o_srf_use         = wdata_q[USE];
    assign o_srf_block_valid = wdata_q[VALID];
    assign o_srf_spare_bit   = wdata_q[SPARE];
    assign o_srf_wen         = srf_wen_q;
    assign o_srf_valid       = srf_valid_q;

endmodule

// File: tb/tb_stat_update_ctrl.sv
// Bench for stat_update_ctrl: table of operations with a status register file
// responder, a response scoreboard queue, and hand-written reset sequences.
module tb_stat_update_ctrl;
    import stat_pkg::*;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       i_req_valid = 1'b0;
    logic       o_req_ready;
    logic [1:0] i_req_op = 2'd0;
    logic [2:0] i_req_addr = 3'd0;
    logic       o_rsp_valid;
    logic       i_rsp_ready = 1'b0;
    logic       o_rsp_was_valid, o_rsp_was_used, o_rsp_spare;
    logic [2:0] o_srf_addr;
    logic       o_srf_use, o_srf_block_valid, o_srf_spare_bit;
    logic       o_srf_wen, o_srf_valid;
    logic       i_srf_use = 1'b0, i_srf_block_valid = 1'b0, i_srf_spare_bit = 1'b0;
    logic       i_srf_valid = 1'b0;
    logic       i_srf_freeze = 1'b0;

    always #5 clk = ~clk;

    stat_update_ctrl #(.ADDR_WIDTH(3)) dut (
        .clk               (clk),
        .arst              (arst),
        .i_req_valid       (i_req_valid),
        .o_req_ready       (o_req_ready),
        .i_req_op          (i_req_op),
        .i_req_addr        (i_req_addr),
        .o_rsp_valid       (o_rsp_valid),
        .i_rsp_ready       (i_rsp_ready),
        .o_rsp_was_valid   (o_rsp_was_valid),
        .o_rsp_was_used    (o_rsp_was_used),
        .o_rsp_spare       (o_rsp_spare),
        .o_srf_addr        (o_srf_addr),
        .o_srf_use         (o_srf_use),
        .o_srf_block_valid (o_srf_block_valid),
        .o_srf_spare_bit   (o_srf_spare_bit),
        .o_srf_wen         (o_srf_wen),
        .o_srf_valid       (o_srf_valid),
        .i_srf_use         (i_srf_use),
        .i_srf_block_valid (i_srf_block_valid),
        .i_srf_spare_bit   (i_srf_spare_bit),
        .i_srf_valid       (i_srf_valid),
        .i_srf_freeze      (i_srf_freeze)
    );

    typedef struct {
        logic [1:0] op;
        logic [2:0] addr;
        logic [2:0] prior;   // {use, valid, spare} returned by the read
        int         lat;
        int         rd_frz;
        int         wr_frz;
        int         stall;
        bit         busy_req;
        logic [2:0] exp_wr;  // expected write word {use, valid, spare}
    } vec_t;

    typedef struct {
        logic [2:0] addr;
        logic [2:0] prior;
        bit         wr;
        logic [2:0] wdata;
    } exp_t;

    vec_t vecs[11];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({o_req_ready, o_rsp_valid, o_rsp_was_valid, o_rsp_was_used, o_rsp_spare,
                    o_srf_addr, o_srf_use, o_srf_block_valid, o_srf_spare_bit,
                    o_srf_wen, o_srf_valid});
    endfunction

    localparam logic [31:0] RESET_OUTS = 32'h1000;

    task automatic run_op(input vec_t v);
        exp_t e;
        int   rdf, wrf, stl, cd, rd_acc, wr_acc, cyc;
        bit   done;
        e.addr  = v.addr;
        e.prior = v.prior;
        e.wr    = (v.op != OP_LOOKUP);
        e.wdata = v.exp_wr;
        rdf = v.rd_frz; wrf = v.wr_frz; stl = v.stall;
        cd = 0; rd_acc = 0; wr_acc = 0; cyc = 0; done = 1'b0;

        @(negedge clk);
        chk("req_ready_idle", 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1;
        i_req_op    = v.op;
        i_req_addr  = v.addr;
        exp_q.push_back(e);

        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            i_req_valid  = v.busy_req;
            i_req_op     = ~v.op;
            i_req_addr   = ~v.addr;
            i_srf_freeze = 1'b0;
            i_rsp_ready  = 1'b0;
            i_srf_valid  = 1'b0;
            {i_srf_use, i_srf_block_valid, i_srf_spare_bit} = 3'($urandom());
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    i_srf_valid = 1'b1;
                    {i_srf_use, i_srf_block_valid, i_srf_spare_bit} = v.prior;
                end
            end
            chk("req_ready_busy", 32'(o_req_ready), 32'd0);
            if (o_srf_valid) begin
                chk("srf_addr", 32'(o_srf_addr), 32'(e.addr));
                if (!o_srf_wen) begin
                    if (rdf > 0) begin
                        rdf--;
                        i_srf_freeze = 1'b1;
                    end else begin
                        rd_acc++;
                        cd = v.lat;
                    end
                end else begin
                    chk("srf_wdata", 32'({o_srf_use, o_srf_block_valid, o_srf_spare_bit}),
                        32'(e.wdata));
                    if (wrf > 0) begin
                        wrf--;
                        i_srf_freeze = 1'b1;
                    end else begin
                        wr_acc++;
                    end
                end
            end
            if (o_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(o_rsp_valid), 32'd0);
                end else begin
                    chk("rsp_prior", 32'({o_rsp_was_used, o_rsp_was_valid, o_rsp_spare}),
                        32'(exp_q[0].prior));
                    if (stl > 0) begin
                        stl--;
                    end else begin
                        i_rsp_ready = 1'b1;
                        void'(exp_q.pop_front());
                        done = 1'b1;
                    end
                end
            end
        end

        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no response handshake within %0d cycles, expected one", cyc);
            exp_q.delete();
        end
        chk("rd_strobes", 32'(rd_acc), 32'd1);
        chk("wr_strobes", 32'(wr_acc), 32'(e.wr));
        chk("occupancy", 32'(cyc),
            32'((e.wr ? 3 : 2) + v.lat + v.rd_frz + v.wr_frz + v.stall));

        @(negedge clk);
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b0;
        i_srf_valid = 1'b0;
        chk("req_ready_after", 32'(o_req_ready), 32'd1);
        chk("rsp_valid_after", 32'(o_rsp_valid), 32'd0);
        chk("srf_valid_after", 32'(o_srf_valid), 32'd0);
    endtask

    initial begin
        //          op         addr  prior   L  rf wf st busy exp_wr
        vecs[0]  = '{OP_TOUCH,  3'd5, 3'b010, 1, 0, 0, 0, 0, 3'b110};
        vecs[1]  = '{OP_FILL,   3'd0, 3'b101, 1, 0, 0, 0, 0, 3'b110};
        vecs[2]  = '{OP_LOOKUP, 3'd7, 3'b011, 1, 0, 0, 0, 0, 3'b000};
        vecs[3]  = '{OP_TOUCH,  3'd3, 3'b000, 2, 3, 3, 0, 0, 3'b100};
        vecs[4]  = '{OP_INVAL,  3'd2, 3'b111, 1, 0, 0, 4, 1, 3'b001};
        vecs[5]  = '{OP_INVAL,  3'd6, 3'b000, 1, 0, 0, 0, 0, 3'b000};
        vecs[6]  = '{OP_FILL,   3'd7, 3'b011, 1, 0, 0, 0, 0, 3'b110};
        vecs[7]  = '{OP_TOUCH,  3'd1, 3'b101, 3, 0, 0, 0, 1, 3'b101};
        vecs[8]  = '{OP_LOOKUP, 3'd0, 3'b100, 2, 2, 0, 2, 0, 3'b000};
        vecs[9]  = '{OP_INVAL,  3'd4, 3'b110, 1, 0, 1, 0, 0, 3'b000};
        vecs[10] = '{OP_TOUCH,  3'd6, 3'b001, 1, 0, 0, 1, 0, 3'b101};

        #2 arst = 1'b1;
        #1 chk("reset_outs_async", outs_vec(), RESET_OUTS);
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        chk("reset_outs", outs_vec(), RESET_OUTS);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i]);
        end

        // Reset in RD_WAIT, followed by a stray read return that must be ignored.
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_op    = OP_TOUCH;
        i_req_addr  = 3'd3;
        @(negedge clk);
        i_req_valid = 1'b0;
        chk("arst_rd_strobe", 32'({o_srf_valid, o_srf_wen}), 32'b10);
        @(negedge clk);
        chk("arst_in_rd_wait", 32'(o_srf_valid), 32'd0);
        arst = 1'b1;
        #1 chk("arst_mid_op", outs_vec(), RESET_OUTS);
        @(negedge clk);
        arst = 1'b0;
        i_srf_valid = 1'b1;
        {i_srf_use, i_srf_block_valid, i_srf_spare_bit} = 3'b111;
        @(negedge clk);
        i_srf_valid = 1'b0;
        chk("stray_ignored", outs_vec(), RESET_OUTS);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_rsp_after_arst", 32'({o_rsp_valid, o_srf_valid, o_req_ready}), 32'b001);
        end

        run_op(vecs[1]);
        run_op(vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
